// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_hazard_ctrl : ID-stage load-use stall / taken-branch flush controller |
// | Optional: HAZARD_PERF_CNT_EN adds the 16-bit stall_cnt_o counter         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_hazard_ctrl #(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned FLUSH_CYCLES    = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] rn_i,
  input  logic [3:0] rm_i,
  input  logic       use_rn_i,
  input  logic       use_rm_i,
  input  logic       ex_load_i,
  input  logic       ex_rf_i,
  input  logic [3:0] ex_rd_i,
  input  logic       br_taken_i,
  output logic       pc_en_o,
  output logic       ifid_en_o,
  output logic       ifid_clr_o,
  output logic       idex_clr_o,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  localparam logic [2:0] c_ldstall_reload = 3'(LOAD_USE_STALLS - 1);
  localparam logic [2:0] c_flush_reload   = 3'(FLUSH_CYCLES - 1);
  localparam bit         c_ldstall_multi  = (LOAD_USE_STALLS > 1);
  localparam bit         c_flush_multi    = (FLUSH_CYCLES > 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       w_hz;

  // R15 reads the PC, never a loaded register, so it cannot create a hazard.
  assign w_hz = ex_load_i & ex_rf_i &
                ((use_rn_i & (rn_i == ex_rd_i) & (rn_i != 4'd15)) |
                 (use_rm_i & (rm_i == ex_rd_i) & (rm_i != 4'd15)));

  always_comb begin
    pc_en_o     = 1'b1;
    ifid_en_o   = 1'b1;
    ifid_clr_o  = 1'b0;
    idex_clr_o  = 1'b0;
    state_o     = r_state;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (CLR) begin
      pc_en_o     = 1'b0;
      ifid_en_o   = 1'b0;
      ifid_clr_o  = 1'b1;
      idex_clr_o  = 1'b1;
      state_o     = 2'd0;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 3'd0;
    end else if (br_taken_i) begin
      // Branch outranks any stall or flush in progress and (re)starts the window.
      ifid_clr_o  = 1'b1;
      idex_clr_o  = 1'b1;
      w_state_nxt = c_flush_multi ? ST_FLUSH : ST_RUN;
      w_cnt_nxt   = c_flush_multi ? c_flush_reload : 3'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hz) begin
            pc_en_o     = 1'b0;
            ifid_en_o   = 1'b0;
            idex_clr_o  = 1'b1;
            w_state_nxt = c_ldstall_multi ? ST_LDSTALL : ST_RUN;
            w_cnt_nxt   = c_ldstall_multi ? c_ldstall_reload : 3'd0;
          end
        end
        ST_LDSTALL: begin
          pc_en_o    = 1'b0;
          ifid_en_o  = 1'b0;
          idex_clr_o = 1'b1;
          w_cnt_nxt  = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = ST_RUN;
        end
        ST_FLUSH: begin
          ifid_clr_o = 1'b1;
          idex_clr_o = 1'b1;
          w_cnt_nxt  = r_cnt - 3'd1;
          if (r_cnt == 3'd1) w_state_nxt = ST_RUN;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_stall_cnt <= 16'd0;
    end else if (!pc_en_o && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_hazard_ctrl : directed bench, DUT A (3 stalls / 2 flush) and       |
// | DUT B (1 stall / 3 flush) share stimulus; HAZARD_PERF_CNT_EN optional    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_id_hazard_ctrl;

  // {pc_en, ifid_en, ifid_clr, idex_clr, state[1:0]}
  localparam logic [5:0] E_RUN  = 6'b1100_00;
  localparam logic [5:0] E_HZ   = 6'b0001_00;
  localparam logic [5:0] E_LD   = 6'b0001_01;
  localparam logic [5:0] E_BR   = 6'b1111_00;
  localparam logic [5:0] E_BRLD = 6'b1111_01;
  localparam logic [5:0] E_FL   = 6'b1111_10;
  localparam logic [5:0] E_CLR  = 6'b0011_00;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] rn_i, rm_i, ex_rd_i;
  logic       use_rn_i, use_rm_i, ex_load_i, ex_rf_i, br_taken_i;
  logic       a_pc, a_ifen, a_ifclr, a_idclr;
  logic       b_pc, b_ifen, b_ifclr, b_idclr;
  logic [1:0] a_st, b_st;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] a_sc, b_sc;
`endif

  always #5 CLK = ~CLK;

  id_hazard_ctrl #(.LOAD_USE_STALLS(3), .FLUSH_CYCLES(2)) u_dut_a (
    .CLK(CLK), .CLR(CLR), .rn_i(rn_i), .rm_i(rm_i), .use_rn_i(use_rn_i),
    .use_rm_i(use_rm_i), .ex_load_i(ex_load_i), .ex_rf_i(ex_rf_i),
    .ex_rd_i(ex_rd_i), .br_taken_i(br_taken_i), .pc_en_o(a_pc),
    .ifid_en_o(a_ifen), .ifid_clr_o(a_ifclr), .idex_clr_o(a_idclr),
    .state_o(a_st)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(a_sc)
`endif
  );

  id_hazard_ctrl #(.LOAD_USE_STALLS(1), .FLUSH_CYCLES(3)) u_dut_b (
    .CLK(CLK), .CLR(CLR), .rn_i(rn_i), .rm_i(rm_i), .use_rn_i(use_rn_i),
    .use_rm_i(use_rm_i), .ex_load_i(ex_load_i), .ex_rf_i(ex_rf_i),
    .ex_rd_i(ex_rd_i), .br_taken_i(br_taken_i), .pc_en_o(b_pc),
    .ifid_en_o(b_ifen), .ifid_clr_o(b_ifclr), .idex_clr_o(b_idclr),
    .state_o(b_st)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(b_sc)
`endif
  );

  typedef struct {
    string      tag;
    logic [5:0] ea;
    logic [5:0] eb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic idle();
    CLR = 1'b0; rn_i = 4'd0; rm_i = 4'd0; ex_rd_i = 4'd0;
    use_rn_i = 1'b0; use_rm_i = 1'b0; ex_load_i = 1'b0; ex_rf_i = 1'b0;
    br_taken_i = 1'b0;
  endtask

  task automatic hazard_rn(input logic [3:0] r, input logic [3:0] rd, input logic rf);
    ex_load_i = 1'b1; ex_rf_i = rf; ex_rd_i = rd; rn_i = r; use_rn_i = 1'b1;
  endtask

  // Inputs are applied just after a falling edge; outputs sampled 1 before rising edge.
  task automatic chk(input string tag, input logic [5:0] ea, input logic [5:0] eb);
    exp_t       e;
    logic [5:0] oa, ob;
    e.tag = tag; e.ea = ea; e.eb = eb;
    sb.push_back(e);
    #4;
    e  = sb.pop_front();
    oa = {a_pc, a_ifen, a_ifclr, a_idclr, a_st};
    ob = {b_pc, b_ifen, b_ifclr, b_idclr, b_st};
    checks++;
    assert (oa === e.ea) else begin
      errors++;
      $error("FAIL %s dutA observed=%b expected=%b", e.tag, oa, e.ea);
    end
    checks++;
    assert (ob === e.eb) else begin
      errors++;
      $error("FAIL %s dutB observed=%b expected=%b", e.tag, ob, e.eb);
    end
    @(negedge CLK);
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [15:0] ea, input logic [15:0] eb);
    #4;
    checks++;
    assert (a_sc === ea) else begin
      errors++;
      $error("FAIL %s dutA stall_cnt observed=%0h expected=%0h", tag, a_sc, ea);
    end
    checks++;
    assert (b_sc === eb) else begin
      errors++;
      $error("FAIL %s dutB stall_cnt observed=%0h expected=%0h", tag, b_sc, eb);
    end
    @(negedge CLK);
  endtask
`endif

  initial begin
    idle();
    CLR = 1'b1;
    @(negedge CLK);
    chk("clr0", E_CLR, E_CLR);
    chk("clr1", E_CLR, E_CLR);
    chk("clr2", E_CLR, E_CLR);
    CLR = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_after_clr", 16'd0, 16'd0);
`endif
    chk("run_after_clr", E_RUN, E_RUN);

    // Load-use on rn, hazard visible for one cycle only
    hazard_rn(4'd4, 4'd4, 1'b1);
    chk("ldu_c1", E_HZ, E_HZ);
    idle();
    chk("ldu_c2", E_LD, E_RUN);
    chk("ldu_c3", E_LD, E_RUN);
    chk("ldu_c4", E_RUN, E_RUN);
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_ldu", 16'd3, 16'd1);
`endif

    // Non-hazards
    hazard_rn(4'd15, 4'd15, 1'b1);
    chk("r15_rn", E_RUN, E_RUN);
    hazard_rn(4'd4, 4'd4, 1'b0);
    chk("no_rf", E_RUN, E_RUN);
    hazard_rn(4'd4, 4'd4, 1'b1);
    use_rn_i = 1'b0;
    chk("no_use", E_RUN, E_RUN);
    use_rm_i = 1'b1; rm_i = 4'd15; ex_rd_i = 4'd15; rn_i = 4'd0;
    chk("r15_rm", E_RUN, E_RUN);
    rm_i = 4'd7; ex_rd_i = 4'd7;
    chk("rm_c1", E_HZ, E_HZ);
    idle();
    chk("rm_c2", E_LD, E_RUN);
    chk("rm_c3", E_LD, E_RUN);
    chk("rm_c4", E_RUN, E_RUN);
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_rm", 16'd6, 16'd2);
`endif

    // Branch in RUN wins over a simultaneous hazard
    hazard_rn(4'd4, 4'd4, 1'b1);
    br_taken_i = 1'b1;
    chk("br_c1", E_BR, E_BR);
    idle();
    chk("br_c2", E_FL, E_FL);
    chk("br_c3", E_RUN, E_FL);
    chk("br_c4", E_RUN, E_RUN);

    // Branch on the 2nd cycle of A's LDSTALL aborts the stall
    hazard_rn(4'd4, 4'd4, 1'b1);
    chk("ldbr_c1", E_HZ, E_HZ);
    idle();
    br_taken_i = 1'b1;
    chk("ldbr_c2", E_BRLD, E_BR);
    idle();
    chk("ldbr_c3", E_FL, E_FL);
    chk("ldbr_c4", E_RUN, E_FL);
    chk("ldbr_c5", E_RUN, E_RUN);
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_ldbr", 16'd7, 16'd3);
`endif

    // Branch during FLUSH restarts the window
    br_taken_i = 1'b1;
    chk("rel_c1", E_BR, E_BR);
    chk("rel_c2", E_FL, E_FL);
    idle();
    chk("rel_c3", E_FL, E_FL);
    chk("rel_c4", E_RUN, E_FL);
    chk("rel_c5", E_RUN, E_RUN);

    // CLR while B is in FLUSH with cnt=2
    br_taken_i = 1'b1;
    chk("clrfl_c1", E_BR, E_BR);
    idle();
    CLR = 1'b1;
    chk("clrfl_c2", E_CLR, E_CLR);
    CLR = 1'b0;
    chk("clrfl_c3", E_RUN, E_RUN);
    chk("clrfl_c4", E_RUN, E_RUN);
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("cnt_clrfl", 16'd0, 16'd0);

    // Continuous hazard keeps pc_en low every cycle; counter must saturate
    hazard_rn(4'd4, 4'd4, 1'b1);
    repeat (65535 + 5) @(negedge CLK);
    chk_cnt("cnt_sat", 16'hFFFF, 16'hFFFF);
    idle();
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk_cnt("cnt_sat_hold", 16'hFFFF, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline hazard controller sitting in the ID stage, directly upstream of the ID/EX pipeline register. It detects load-use hazards between the instruction in ID and the load in EX, and branch-taken flushes resolved in EX. It drives the PC/IF-ID enables and the synchronous clears of IF/ID and ID/EX. It holds a small FSM with a down-counter, so multi-cycle stall and flush windows are configurable.

## Interface
- LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard (legal 1..7)
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX clears stay asserted after a taken branch (legal 1..7)

Ports:
- CLK  in  1  clock; all state updates on posedge CLK
- CLR  in  1  reset, synchronous, active-high
- rn_i  in  4  ID-stage first source register
- rm_i  in  4  ID-stage second source register
- use_rn_i  in  1  ID instruction reads rn_i
- use_rm_i  in  1  ID instruction reads rm_i
- ex_load_i  in  1  EX instruction is a load (ID/EX load output)
- ex_rf_i  in  1  EX instruction writes the register file (ID/EX rf output)
- ex_rd_i  in  4  EX destination register
- br_taken_i  in  1  EX branch resolved taken this cycle
- pc_en_o  out  1  PC load enable
- ifid_en_o  out  1  IF/ID load enable
- ifid_clr_o  out  1  IF/ID synchronous clear
- idex_clr_o  out  1  ID/EX synchronous clear (drives ID/EX CLR)
- state_o  out  2  current state: 0 RUN, 1 LDSTALL, 2 FLUSH
- stall_cnt_o  out  16  stall-cycle count (only with HAZARD_PERF_CNT_EN)

## Operation
- Hazard term: `hz = ex_load_i & ex_rf_i & ((use_rn_i & rn_i==ex_rd_i & rn_i!=15) | (use_rm_i & rm_i==ex_rd_i & rm_i!=15))`. R15 is never a hazard source.
- Outputs are combinational from the registered state, the 3-bit counter `cnt`, and the current inputs. State and `cnt` are registered.
- Priority: CLR > br_taken_i > state hold > hz.
- RUN:
  - Default outputs: pc_en=1, ifid_en=1, ifid_clr=0, idex_clr=0.
  - If br_taken_i: pc_en=1, ifid_clr=1, idex_clr=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - Else if hz: pc_en=0, ifid_en=0, idex_clr=1. If LOAD_USE_STALLS>1, go to LDSTALL with cnt=LOAD_USE_STALLS-1; otherwise stay in RUN.
- LDSTALL: pc_en=0, ifid_en=0, idex_clr=1. Decrement cnt; return to RUN when cnt reaches 1→0 (the last stall cycle is the one with cnt=1). hz is ignored in this state.
- FLUSH: pc_en=1, ifid_clr=1, idex_clr=1. Decrement cnt; return to RUN when cnt=1.
- Branch during LDSTALL: abort the stall (the branch is older), apply the RUN branch response, and load cnt as for RUN.
- Branch during FLUSH: reload cnt=FLUSH_CYCLES-1 (restart the window). If FLUSH_CYCLES=1, go to RUN.
- CLR (synchronous, any state): state←RUN, cnt←0. While CLR is high, outputs are forced to pc_en=0, ifid_en=0, ifid_clr=1, idex_clr=1, state_o=0.

## Timing
- Hazard detection has zero latency: the stall/clear outputs are valid in the same cycle hz or br_taken_i is asserted, and take effect at that cycle's posedge.
- A load-use hazard costs exactly LOAD_USE_STALLS cycles of pc_en=0. A taken branch costs exactly FLUSH_CYCLES cycles of ifid_clr=1.
- First cycle after CLR deasserts: state RUN, outputs at RUN defaults. stall_cnt_o=0.
- cnt never wraps; it is only loaded on entry or reload.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o is present, a 16-bit register cleared by CLR.
  - It increments on every non-CLR cycle with pc_en_o=0.
  - It saturates at 0xFFFF.
- HAZARD_PERF_CNT_EN undefined: stall_cnt_o and its register are absent; all other behaviour is identical.

## Test plan
- CLR held 3 cycles -> pc_en=0, ifid_clr=1, idex_clr=1 during CLR; next cycle state_o=0, pc_en=1, stall_cnt_o=0.
- ex_load=1, ex_rf=1, ex_rd=4, rn=4, use_rn=1, LOAD_USE_STALLS=3 -> pc_en=0 and idex_clr=1 for exactly 3 cycles, state_o=1 for cycles 2-3, then RUN. stall_cnt_o=3.
- Same setup with rn=15, ex_rd=15 -> no stall. Same setup with ex_rf=0 -> no stall.
- br_taken=1 in RUN, FLUSH_CYCLES=2 -> ifid_clr=idex_clr=1 for 2 cycles, pc_en=1 throughout, then RUN.
- br_taken asserted on the 2nd cycle of a 3-cycle LDSTALL -> pc_en=1 and ifid_clr=1 that cycle; enter FLUSH (or RUN if FLUSH_CYCLES=1); the stall is not resumed.
- CLR asserted mid-FLUSH with cnt=2 -> next cycle state_o=0 and clears deasserted. With the macro on, force 0xFFFF stall cycles plus 5 more -> stall_cnt_o holds 0xFFFF.
